// File: rtl/iic_slave_regif.sv
// I2C target with a register-port back end: decodes device and register address,
// issues write strobes and fetches read bytes through a request/response port.
module iic_slave_regif #(
  parameter logic [6:0] DEVICE_ADDR    = 7'h03,
  parameter int         REG_ADDR_BYTES = 2,
  parameter int         DATA_WIDTH     = 8,
  parameter int         REG_ADDR_WIDTH = 8 * REG_ADDR_BYTES
) (
  input  logic                      sysclk,
  input  logic                      rstn,
  input  logic                      iic_scl,
  input  logic                      iic_sda_i,
  output logic                      iic_sda_oe,
  output logic                      reg_wr_valid,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  output logic                      reg_rd_req,
  input  logic [DATA_WIDTH-1:0]     reg_rd_data,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic                      busy,
  output logic                      done
);

  // state    | meaning
  // IDLE     | waiting for START (also after address mismatch or read NACK)
  // DEV_ADDR | shifting in 7-bit device address + R/W
  // DEV_ACK  | acknowledging the device address
  // REG_ADDR | shifting in one register-address byte
  // REG_ACK  | acknowledging a register-address byte
  // WR_DATA  | shifting in a write data byte
  // WR_ACK   | acknowledging a write data byte
  // RD_LOAD  | fetching the read byte from the register port
  // RD_DATA  | driving a read byte onto SDA
  // RD_ACK   | sampling the master's ACK/NACK
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] DEV_ADDR = 4'd1;
  localparam logic [3:0] DEV_ACK  = 4'd2;
  localparam logic [3:0] REG_ADDR = 4'd3;
  localparam logic [3:0] REG_ACK  = 4'd4;
  localparam logic [3:0] WR_DATA  = 4'd5;
  localparam logic [3:0] WR_ACK   = 4'd6;
  localparam logic [3:0] RD_LOAD  = 4'd7;
  localparam logic [3:0] RD_DATA  = 4'd8;
  localparam logic [3:0] RD_ACK   = 4'd9;

  localparam logic [1:0] ADDR_BYTES = 2'(REG_ADDR_BYTES);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ONE = REG_ADDR_WIDTH'(1);

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] rx_byte;
  logic       rw;
  logic [1:0] addr_byte_cnt;
  logic [1:0] rd_cnt;

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {iic_scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {iic_sda_i, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_byte   = {shift[6:0], sda_s2};

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      bit_cnt       <= 4'd0;
      shift         <= 8'h00;
      rw            <= 1'b0;
      addr_byte_cnt <= 2'd0;
      rd_cnt        <= 2'd0;
      iic_sda_oe    <= 1'b0;
      reg_wr_valid  <= 1'b0;
      reg_wr_data   <= '0;
      reg_rd_req    <= 1'b0;
      reg_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      reg_wr_valid <= 1'b0;
      reg_rd_req   <= 1'b0;
      done         <= 1'b0;
      // post-strobe increment so the strobe cycle carries the pre-increment address
      if (reg_wr_valid) reg_addr <= reg_addr + ADDR_ONE;

      if (stop_det) begin
        state      <= IDLE;
        iic_sda_oe <= 1'b0;
        done       <= busy;
        busy       <= 1'b0;
      end else if (start_det) begin
        state         <= DEV_ADDR;
        bit_cnt       <= 4'd0;
        addr_byte_cnt <= 2'd0;
        iic_sda_oe    <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              rw      <= sda_s2;
              if (rx_byte[7:1] == DEVICE_ADDR) begin
                busy  <= 1'b1;
                state <= DEV_ACK;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
          // first falling edge starts the ACK bit, the second one ends it
          DEV_ACK, REG_ACK, WR_ACK: if (scl_fall) begin
            if (!iic_sda_oe) begin
              iic_sda_oe <= 1'b1;
              if (state == DEV_ACK && rw) begin
                state      <= RD_LOAD;
                reg_rd_req <= 1'b1;
                rd_cnt     <= 2'd0;
              end
            end else begin
              iic_sda_oe <= 1'b0;
              bit_cnt    <= 4'd0;
              if (state == WR_ACK || (state == REG_ACK && addr_byte_cnt == ADDR_BYTES))
                state <= WR_DATA;
              else
                state <= REG_ADDR;
            end
          end
          REG_ADDR: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt       <= 4'd0;
              reg_addr      <= REG_ADDR_WIDTH'({reg_addr, rx_byte});
              addr_byte_cnt <= addr_byte_cnt + 2'd1;
              state         <= REG_ACK;
            end
          end
          WR_DATA: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt      <= 4'd0;
              reg_wr_valid <= 1'b1;
              reg_wr_data  <= rx_byte;
              state        <= WR_ACK;
            end
          end
          RD_LOAD: begin
            rd_cnt <= rd_cnt + 2'd1;
            if (rd_cnt == 2'd2) begin
              shift   <= reg_rd_data;
              bit_cnt <= 4'd0;
              state   <= RD_DATA;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              iic_sda_oe <= 1'b0;
              state      <= RD_ACK;
            end else begin
              iic_sda_oe <= ~shift[7];
              shift      <= {shift[6:0], 1'b0};
              bit_cnt    <= bit_cnt + 4'd1;
            end
          end
          RD_ACK: if (scl_rise) begin
            if (!sda_s2) begin
              reg_addr   <= reg_addr + ADDR_ONE;
              reg_rd_req <= 1'b1;
              rd_cnt     <= 2'd0;
              state      <= RD_LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
